// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared state encoding, widths and geometry defaults for game_sequencer.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LOST      = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_PAUSE     = 3'd5
    } state_t;

    localparam int TIMER_W = 8;
    localparam int LIVES_W = 3;
    localparam logic [9:0] LOST_Y_PIXEL_DEFAULT = 10'd470;

    // Game logic needs 3 cycles after each START_UPDATE before it can take another.
    localparam logic [1:0] UPDATE_GAP = 2'd3;

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// rtl/game_sequencer_frame_timer.sv - saturating FRAME_END counter with clear, freeze and terminal compare.
module game_sequencer_frame_timer
    import game_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_freeze,
    input  logic               i_inc,
    input  logic [TIMER_W-1:0] i_limit,
    output logic               o_done,
    output logic               o_last
);

    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] r_count;
    logic [TIMER_W:0]   w_count_plus;

    assign w_count_plus = {1'b0, r_count} + {{TIMER_W{1'b0}}, 1'b1};
    assign o_done       = (r_count == i_limit);
    // o_last: the next increment reaches the limit
    assign o_last       = (w_count_plus == {1'b0, i_limit});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !i_freeze && !o_done && (r_count != '1)) begin
            r_count <= r_count + TIMER_ONE;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - per-frame scheduler for serve/play/lost/game-over flow of the game logic.
// Optional pause state enabled by defining PAUSE_EN.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned LIVES_INIT         = 3,
    parameter int unsigned SERVE_DELAY_FRAMES = 30,
    parameter int unsigned LOST_DELAY_FRAMES  = 60,
    parameter int unsigned GAMEOVER_FRAMES    = 180,
    parameter logic [9:0]  LOST_Y_PIXEL       = LOST_Y_PIXEL_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_end,
    input  logic               i_btn_start,
    input  logic               i_btn_pause,
    input  logic [9:0]         i_ball_y_pixel,
    output logic               o_start_update,
    output logic               o_release_ok,
    output logic               o_ball_reset,
    output logic [LIVES_W-1:0] o_lives,
    output logic               o_game_over,
    output logic               o_paused
);

    localparam logic [LIVES_W-1:0] LIVES_RST  = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [TIMER_W-1:0] SERVE_LIM  = TIMER_W'(SERVE_DELAY_FRAMES);
    localparam logic [TIMER_W-1:0] LOST_LIM   = TIMER_W'(LOST_DELAY_FRAMES);
    localparam logic [TIMER_W-1:0] GOVER_LIM  = TIMER_W'(GAMEOVER_FRAMES);

    state_t             r_state;
    state_t             w_state_next;
    state_t             w_resume_state;
    logic               r_start_update;
    logic               w_start_update_next;
    logic               r_ball_reset;
    logic               w_ball_reset_next;
    logic [LIVES_W-1:0] r_lives;
    logic [LIVES_W-1:0] w_lives_next;
    logic               r_btn_start_q;
    logic [1:0]         r_busy;
    logic               w_frame;
    logic               w_start_rise;
    logic               w_pause_rise;
    logic               w_release_ok;
    logic               w_timer_clear;
    logic               w_timer_inc;
    logic               w_timer_freeze;
    logic [TIMER_W-1:0] w_timer_limit;
    logic               w_timer_done;
    logic               w_timer_last;

    // A frame strobe arriving while the game logic is still busy is dropped entirely.
    assign w_frame        = i_frame_end && (r_busy == 2'd0);
    assign w_start_rise   = i_btn_start && !r_btn_start_q;
    assign w_release_ok   = (r_state == ST_SERVE) && i_btn_start && w_timer_done;
    assign w_timer_freeze = (r_state == ST_PAUSE);

    game_sequencer_frame_timer u_frame_timer (
        .i_clk    (i_clk),
        .i_rst    (i_reset),
        .i_clear  (w_timer_clear),
        .i_freeze (w_timer_freeze),
        .i_inc    (w_timer_inc),
        .i_limit  (w_timer_limit),
        .o_done   (w_timer_done),
        .o_last   (w_timer_last)
    );

    always_comb begin
        w_timer_limit = SERVE_LIM;
        case (r_state)
            ST_LOST:      w_timer_limit = LOST_LIM;
            ST_GAME_OVER: w_timer_limit = GOVER_LIM;
            default:      w_timer_limit = SERVE_LIM;
        endcase
    end

    always_comb begin
        w_state_next        = r_state;
        w_start_update_next = 1'b0;
        w_ball_reset_next   = 1'b0;
        w_lives_next        = r_lives;
        w_timer_clear       = 1'b0;
        w_timer_inc         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_lives_next = LIVES_RST;
                if (w_start_rise) begin
                    w_state_next      = ST_SERVE;
                    w_ball_reset_next = 1'b1;
                    w_timer_clear     = 1'b1;
                end
            end
            ST_SERVE: begin
                if (w_pause_rise) begin
                    w_state_next = ST_PAUSE;
                end else if (w_frame) begin
                    w_start_update_next = 1'b1;
                    w_timer_inc         = 1'b1;
                    if (w_release_ok) begin
                        w_state_next = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (w_pause_rise) begin
                    w_state_next = ST_PAUSE;
                end else if (w_frame) begin
                    if (i_ball_y_pixel >= LOST_Y_PIXEL) begin
                        if (r_lives != '0) begin
                            w_lives_next = r_lives - LIVES_ONE;
                        end
                        w_timer_clear = 1'b1;
                        w_state_next  = ST_LOST;
                    end else begin
                        w_start_update_next = 1'b1;
                    end
                end
            end
            ST_LOST: begin
                if (w_frame) begin
                    if (w_timer_last) begin
                        w_timer_clear = 1'b1;
                        if (r_lives == '0) begin
                            w_state_next = ST_GAME_OVER;
                        end else begin
                            w_ball_reset_next = 1'b1;
                            w_state_next      = ST_SERVE;
                        end
                    end else begin
                        w_timer_inc = 1'b1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (w_frame) begin
                    if (w_timer_last) begin
                        w_timer_clear = 1'b1;
                        w_lives_next  = LIVES_RST;
                        w_state_next  = ST_IDLE;
                    end else begin
                        w_timer_inc = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_pause_rise) begin
                    w_state_next = w_resume_state;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_start_update <= 1'b0;
            r_ball_reset   <= 1'b0;
            r_lives        <= LIVES_RST;
            r_btn_start_q  <= 1'b0;
            r_busy         <= 2'd0;
        end else begin
            r_state        <= w_state_next;
            r_start_update <= w_start_update_next;
            r_ball_reset   <= w_ball_reset_next;
            r_lives        <= w_lives_next;
            r_btn_start_q  <= i_btn_start;
            if (w_start_update_next) begin
                r_busy <= UPDATE_GAP;
            end else if (r_busy != 2'd0) begin
                r_busy <= r_busy - 2'd1;
            end
        end
    end

`ifdef PAUSE_EN
    logic   r_btn_pause_q;
    state_t r_resume_state;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_pause_q  <= 1'b0;
            r_resume_state <= ST_PLAY;
        end else begin
            r_btn_pause_q <= i_btn_pause;
            if ((w_state_next == ST_PAUSE) && (r_state != ST_PAUSE)) begin
                r_resume_state <= r_state;
            end
        end
    end

    assign w_pause_rise   = i_btn_pause && !r_btn_pause_q;
    assign w_resume_state = r_resume_state;
    assign o_paused       = (r_state == ST_PAUSE);
`else
    logic w_unused_btn_pause;

    assign w_unused_btn_pause = i_btn_pause;
    assign w_pause_rise       = 1'b0;
    assign w_resume_state     = ST_IDLE;
    assign o_paused           = 1'b0;
`endif

    assign o_start_update = r_start_update;
    assign o_release_ok   = w_release_ok;
    assign o_ball_reset   = r_ball_reset;
    assign o_lives        = r_lives;
    assign o_game_over    = (r_state == ST_GAME_OVER);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer (default parameters, PAUSE_EN optional).
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       fe;
    logic       bs;
    logic       bp;
    logic [9:0] by;
    logic       su_o;
    logic       rok_o;
    logic       br_o;
    logic [2:0] lives_o;
    logic       go_o;
    logic       paused_o;

    int n_total = 0;
    int n_bad   = 0;

    game_sequencer dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_frame_end    (fe),
        .i_btn_start    (bs),
        .i_btn_pause    (bp),
        .i_ball_y_pixel (by),
        .o_start_update (su_o),
        .o_release_ok   (rok_o),
        .o_ball_reset   (br_o),
        .o_lives        (lives_o),
        .o_game_over    (go_o),
        .o_paused       (paused_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One FRAME_END strobe followed by 7 quiet cycles; counts update and ball-reset pulses.
    task automatic frame(output int su, output int br);
        su = 0;
        br = 0;
        fe = 1'b1;
        step();
        fe = 1'b0;
        su += int'(su_o);
        br += int'(br_o);
        repeat (7) begin
            step();
            su += int'(su_o);
            br += int'(br_o);
        end
    endtask

    task automatic press_start();
        bs = 1'b1;
        step();
        check("start_ball_reset", int'(br_o), 1);
        check("start_release_ok", int'(rok_o), 0);
        step();
        check("start_ball_reset_once", int'(br_o), 0);
    endtask

    task automatic serve_to_play();
        int su, br;
        bs = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            frame(su, br);
            check("serve_update", su, 1);
            check("serve_release_ok", int'(rok_o), (k == 30) ? 1 : 0);
        end
        bs = 1'b0;
    endtask

    task automatic lose_life(input int exp_lives, input int exp_go);
        int su, br;
        int su_sum = 0;
        int br_sum = 0;
        by = 10'd470;
        frame(su, br);
        check("loss_no_update", su, 0);
        check("loss_lives", int'(lives_o), exp_lives);
        by = 10'd100;
        for (int k = 1; k <= 59; k++) begin
            frame(su, br);
            su_sum += su;
            br_sum += br;
        end
        check("lost_no_update", su_sum, 0);
        check("lost_no_ball_reset", br_sum, 0);
        check("lost_game_over_early", int'(go_o), 0);
        frame(su, br);
        check("lost_end_ball_reset", br, (exp_go != 0) ? 0 : 1);
        check("lost_end_game_over", int'(go_o), exp_go);
    endtask

    initial begin
        int su, br, sum;
        rst = 1'b1;
        fe  = 1'b0;
        bs  = 1'b0;
        bp  = 1'b0;
        by  = 10'd100;
        repeat (3) step();
        check("rst_start_update", int'(su_o), 0);
        check("rst_release_ok", int'(rok_o), 0);
        check("rst_ball_reset", int'(br_o), 0);
        check("rst_lives", int'(lives_o), 3);
        check("rst_game_over", int'(go_o), 0);
        check("rst_paused", int'(paused_o), 0);
        rst = 1'b0;
        step();

        sum = 0;
        for (int k = 0; k < 5; k++) begin
            frame(su, br);
            sum += su;
        end
        check("idle_no_update", sum, 0);
        check("idle_lives", int'(lives_o), 3);
        check("idle_game_over", int'(go_o), 0);

        press_start();
        serve_to_play();

        frame(su, br);
        check("play_update", su, 1);
        by = 10'd469;
        frame(su, br);
        check("play_y469_update", su, 1);
        by = 10'd100;

        // FRAME_END 2 cycles after a pulse is dropped, 4 cycles after is taken.
        fe = 1'b1;
        step();
        check("gap_first", int'(su_o), 1);
        fe = 1'b0;
        step();
        fe = 1'b1;
        step();
        fe = 1'b0;
        check("gap_second_fe_ignored", int'(su_o), 0);
        step();
        check("gap_no_late_pulse", int'(su_o), 0);
        fe = 1'b1;
        step();
        fe = 1'b0;
        check("gap_fourth_accepted", int'(su_o), 1);
        repeat (6) step();

        lose_life(2, 0);
        serve_to_play();
        lose_life(1, 0);
        serve_to_play();
        lose_life(0, 1);

        sum = 0;
        for (int k = 1; k <= 179; k++) begin
            frame(su, br);
            sum += su;
        end
        check("gover_no_update", sum, 0);
        check("gover_held", int'(go_o), 1);
        frame(su, br);
        check("gover_exit", int'(go_o), 0);
        check("gover_lives_restored", int'(lives_o), 3);
        frame(su, br);
        check("gover_idle_no_update", su, 0);

        press_start();
        serve_to_play();

`ifdef PAUSE_EN
        bp = 1'b1;
        step();
        bp = 1'b0;
        check("pause_enter", int'(paused_o), 1);
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            frame(su, br);
            sum += su;
        end
        check("pause_no_update", sum, 0);
        bp = 1'b1;
        step();
        bp = 1'b0;
        check("pause_exit", int'(paused_o), 0);
        frame(su, br);
        check("pause_resume_update", su, 1);
`else
        bp = 1'b1;
        step();
        bp = 1'b0;
        check("pause_disabled", int'(paused_o), 0);
        frame(su, br);
        check("pause_disabled_update", su, 1);
`endif

        lose_life(2, 0);
        serve_to_play();

        fe = 1'b1;
        step();
        check("rst_mid_pulse", int'(su_o), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_start_update", int'(su_o), 0);
        check("rst_mid_lives", int'(lives_o), 3);
        check("rst_mid_ball_reset", int'(br_o), 0);
        check("rst_mid_game_over", int'(go_o), 0);
        check("rst_mid_paused", int'(paused_o), 0);
        fe = 1'b0;
        step();
        check("rst_mid_next_cycle", int'(su_o), 0);
        check("rst_mid_release_ok", int'(rok_o), 0);
        rst = 1'b0;
        frame(su, br);
        check("rst_then_idle", su, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
